serial_subtractor16: RTL and testbench

SERIAL_SUBTRACTOR16 -- requirements
Module: serial_subtractor16

---
 rtl/serial_subtractor16.sv | 151 +++++++++++++++
 tb/tb_serial_subtractor16.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor16.sv
// serial_subtractor16
//   Bit-serial 16-bit subtractor computing a - b - borrowInput (mod 2^16),
//   one bit per clock, LSB first. A start accepted in IDLE latches the
//   operands; 16 RUN edges later the result registers update together and
//   a one-cycle done pulse follows in DONE.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start        in   begin a subtraction (sampled only in IDLE)
//   a            in   [15:0] minuend, latched on the accepted start edge
//   b            in   [15:0] subtrahend, latched on the accepted start edge
//   borrowInput  in   borrow into bit 0, latched on the accepted start edge
//   diff         out  [15:0] registered difference
//   borrowOutput out  borrow out of bit 15
//   overflow     out  two's-complement signed overflow
//   zero         out  high when diff == 0
//   busy         out  high in RUN and DONE
//   done         out  one-cycle pulse when a new result is valid
module serial_subtractor16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        borrowInput,
  output logic [15:0] diff,
  output logic        borrowOutput,
  output logic        overflow,
  output logic        zero,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic [15:0] a_q,     a_d;
  logic [15:0] b_q,     b_d;
  logic [15:0] part_q,  part_d;
  logic        br_q,    br_d;
  logic [15:0] diff_q,  diff_d;
  logic        bo_q,    bo_d;
  logic        ov_q,    ov_d;
  logic        zero_q,  zero_d;

  // Current bit slice: operand LSBs and the running borrow.
  logic ai;
  logic bi;
  logic d_bit;
  logic br_next;

  always_comb begin
    ai      = a_q[0];
    bi      = b_q[0];
    d_bit   = ai ^ bi ^ br_q;
    br_next = (~ai & bi) | (~ai & br_q) | (bi & br_q);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    part_d  = part_q;
    br_d    = br_q;
    diff_d  = diff_q;
    bo_d    = bo_q;
    ov_d    = ov_q;
    zero_d  = zero_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = borrowInput;
          part_d  = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        a_d    = {1'b0, a_q[15:1]};
        b_d    = {1'b0, b_q[15:1]};
        br_d   = br_next;
        part_d = {d_bit, part_q[15:1]};
        // Counter reaches 15 only on the last bit, so the natural 4-bit
        // wrap back to 0 coincides with the move into DONE.
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          // On the last bit the operand LSBs are the original sign bits,
          // so overflow can be formed without keeping separate copies.
          diff_d  = part_d;
          bo_d    = br_next;
          ov_d    = (ai != bi) && (d_bit != ai);
          zero_d  = (part_d == 16'h0000);
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      bo_q    <= 1'b0;
      ov_q    <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      part_q  <= part_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      bo_q    <= bo_d;
      ov_q    <= ov_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    diff         = diff_q;
    borrowOutput = bo_q;
    overflow     = ov_q;
    zero         = zero_q;
    busy         = (state_q == RUN) || (state_q == DONE);
    done         = (state_q == DONE);
  end

endmodule

// File: tb/tb_serial_subtractor16.sv
// tb_serial_subtractor16
//   Scoreboard bench for serial_subtractor16: expected results are queued
//   when a start is driven and checked by a monitor whenever done pulses.
module tb_serial_subtractor16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        borrowInput = 1'b0;
  logic [15:0] diff;
  logic        borrowOutput;
  logic        overflow;
  logic        zero;
  logic        busy;
  logic        done;

  serial_subtractor16 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .a            (a),
    .b            (b),
    .borrowInput  (borrowInput),
    .diff         (diff),
    .borrowOutput (borrowOutput),
    .overflow     (overflow),
    .zero         (zero),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] diff;
    logic        bo;
    logic        ov;
    logic        z;
  } res_t;

  res_t sb[$];
  int pass_cnt  = 0;
  int total_cnt = 0;
  int done_cnt  = 0;

  function automatic res_t model(input logic [15:0] x, input logic [15:0] y, input logic bi);
    logic [16:0] r;
    res_t e;
    r    = {1'b0, x} - {1'b0, y} - {16'b0, bi};
    e.diff = r[15:0];
    e.bo   = r[16];
    e.ov   = (x[15] != y[15]) && (r[15] != x[15]);
    e.z    = (r[15:0] == 16'h0000);
    return e;
  endfunction

  // Result monitor: every done pulse must match the oldest queued result.
  res_t mon_exp;
  res_t mon_act;
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      mon_act = {diff, borrowOutput, overflow, zero};
      total_cnt++;
      if (sb.size() == 0) begin
        $display("FAIL result: unexpected done, diff=%h bo=%b ov=%b z=%b, required no done",
                 diff, borrowOutput, overflow, zero);
      end else begin
        mon_exp = sb.pop_front();
        if (mon_act !== mon_exp)
          $display("FAIL result: diff=%h bo=%b ov=%b z=%b, required diff=%h bo=%b ov=%b z=%b",
                   mon_act.diff, mon_act.bo, mon_act.ov, mon_act.z,
                   mon_exp.diff, mon_exp.bo, mon_exp.ov, mon_exp.z);
        else
          pass_cnt++;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic start_op(input logic [15:0] x, input logic [15:0] y, input logic bi,
                          input bit push);
    a = x;
    b = y;
    borrowInput = bi;
    start = 1'b1;
    if (push) sb.push_back(model(x, y, bi));
    @(negedge clk);
    start = 1'b0;
    // Scramble inputs: the latched operands alone must decide the result.
    a = 16'($urandom);
    b = 16'($urandom);
    borrowInput = 1'($urandom);
  endtask

  // Counts negedges until done (bounded); held reports whether the result
  // outputs stayed put before done.
  task automatic wait_done(output int lat, output bit held);
    logic [18:0] snap;
    snap = {diff, borrowOutput, overflow, zero};
    held = 1'b1;
    lat  = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!done && ({diff, borrowOutput, overflow, zero} !== snap)) held = 1'b0;
    end while (!done && lat < 40);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({diff, borrowOutput, overflow, zero, busy, done} !== {16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0})
      $display("FAIL reset_state: diff=%h bo=%b ov=%b z=%b busy=%b done=%b, required 0000 0 0 1 0 0",
               diff, borrowOutput, overflow, zero, busy, done);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_one(input logic [15:0] x, input logic [15:0] y, input logic bi,
                         input string name);
    int lat;
    bit held;
    start_op(x, y, bi, 1'b1);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL %s_busy_run: busy=%b, required 1", name, busy);
    else pass_cnt++;
    wait_done(lat, held);
    total_cnt++;
    if (lat !== 16) $display("FAIL %s_latency: %0d cycles, required 16", name, lat);
    else pass_cnt++;
    total_cnt++;
    if (held !== 1'b1) $display("FAIL %s_hold: outputs changed before done, required held", name);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL %s_busy_done: busy=%b, required 1", name, busy);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({done, busy} !== 2'b00)
      $display("FAIL %s_done_pulse: done=%b busy=%b after DONE, required 0 0", name, done, busy);
    else pass_cnt++;
  endtask

  task automatic test_directed();
    run_one(16'h0005, 16'h0003, 1'b0, "sub_5_3");
    run_one(16'h0003, 16'h0005, 1'b0, "sub_3_5");
    run_one(16'h8000, 16'h0001, 1'b0, "sub_ovf");
    run_one(16'h1234, 16'h1233, 1'b1, "sub_zero");
    run_one(16'h7FFF, 16'hFFFF, 1'b1, "sub_neg_ovf");
    run_one(16'h0000, 16'h0000, 1'b1, "sub_all_borrow");
  endtask

  // Each op starts in the IDLE cycle right after the previous DONE.
  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++)
      run_one(16'($urandom), 16'($urandom), 1'($urandom), "b2b");
  endtask

  task automatic test_ignore_start();
    int lat;
    int dc0;
    bit held;
    dc0 = done_cnt;
    start_op(16'h4321, 16'h0123, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    a = 16'hAAAA;
    b = 16'h5555;
    borrowInput = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, held);
    total_cnt++;
    if (lat !== 10) $display("FAIL ignore_latency: %0d cycles after pulse, required 10", lat);
    else pass_cnt++;
    repeat (24) @(negedge clk);
    total_cnt++;
    if (done_cnt - dc0 !== 1) $display("FAIL ignore_done_count: %0d pulses, required 1", done_cnt - dc0);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL ignore_busy: busy=%b, required 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_start_in_done();
    int lat;
    bit held;
    start_op(16'h9000, 16'h0F00, 1'b0, 1'b1);
    wait_done(lat, held);
    a = 16'h1111;
    b = 16'h2222;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL done_start_busy1: busy=%b, required 0", busy);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL done_start_busy2: busy=%b, required 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int dc0;
    bit held;
    dc0 = done_cnt;
    start_op(16'h0F0F, 16'h0001, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({diff, borrowOutput, overflow, zero, busy, done} !== {16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0})
      $display("FAIL abort_reset: diff=%h bo=%b ov=%b z=%b busy=%b done=%b, required 0000 0 0 1 0 0",
               diff, borrowOutput, overflow, zero, busy, done);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    total_cnt++;
    if (done_cnt !== dc0) $display("FAIL abort_no_done: %0d pulses, required 0", done_cnt - dc0);
    else pass_cnt++;
    total_cnt++;
    if ({diff, zero, busy} !== {16'h0000, 1'b1, 1'b0})
      $display("FAIL abort_hold: diff=%h z=%b busy=%b, required 0000 1 0", diff, zero, busy);
    else pass_cnt++;
    start_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
    wait_done(lat, held);
    total_cnt++;
    if (lat !== 16) $display("FAIL after_reset_latency: %0d cycles, required 16", lat);
    else pass_cnt++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_ignore_start();
    test_start_in_done();
    test_reset_mid_run();
    repeat (2) @(negedge clk);
    total_cnt++;
    if (sb.size() !== 0) $display("FAIL scoreboard_drain: %0d results pending, required 0", sb.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
